riscv_mc_control: RTL and testbench
===================================

Name: riscv_mc_control

Overview:
Multi-cycle control unit for the RISC-V multi-cycle processor.
- A Moore-style FSM that sequences the shared ALU, register file, IR/PC registers and the unified memory port through fetch, decode, execute, memory and writeback phases.
- Generates the 3-bit ALU `sel` and all datapath mux selects and write strobes.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU Zero flag
- negative  in  1  ALU Negative flag
- overflow  in  1  ALU Overflow flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC register load
- adr_src  out  1  0=PC, 1=ALUOut as memory address
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR/OldPC load
- reg_write  out  1  register file write
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RegA
- alu_src_b  out  2  00 RegB, 01 ImmExt, 10 const 4
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- alu_sel  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  sticky illegal-instruction flag
- instret  out  INSTRET_W  retired instruction count

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low sets state=FETCH and instret=0 immediately, including mid-access.
  - All write strobes (pc_write, ir_write, mem_write, reg_write) are forced 0 while rst_n=0.
  - Non-strobe outputs carry FETCH values during reset; illegal=0.
- Unlisted outputs are 0 in every state.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_sel=000, result_src=10; ir_write=pc_write=mem_ready. Holds until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, alu_sel=000 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode, or unsupported funct3 -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, alu_sel=000; imm_src=00 for lw, 01 for sw. Goes to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 every cycle held. Holds until mem_ready, then goes to FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, funct-decoded alu_sel, then ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, imm_src=00, funct-decoded alu_sel (funct7b5 ignored, never sub), then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_sel=001, result_src=00; pc_write=zero for beq (funct3=000). Then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_sel=000, result_src=00, pc_write=1, then ALUWB.
- ILLEGAL: all strobes 0, illegal=1; absorbing until reset.
- funct decode:
  - 000 -> add, or sub when R-type and funct7b5=1
  - 010 -> 101 (slt)
  - 110 -> 011 (or)
  - 111 -> 010 (and)
  - other funct3 on R/I-type -> ILLEGAL
- Load/store funct3 must be 010; any other value -> ILLEGAL.
- instret increments by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH, or MEMWRITE with mem_ready=1. JAL retires via ALUWB (counted once). Wraps to 0.
- Cycle counts with mem_ready tied high:
  - R/I-type 4, lw 5, sw 4, beq 3, jal 4.
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.

Optional Feature:
BRANCH_EXT_EN
- Defined: BRANCH also accepts funct3=001 (bne, pc_write=~zero) and 100 (blt, pc_write=negative^overflow).
- Undefined: those funct3 values go to ILLEGAL; negative/overflow ports remain but are unused.

Decomposition:
- Package riscv_mc_pkg:
  - state enum
  - opcode localparams
  - ALU sel constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - mux-select encodings
- Sub-module riscv_alu_decoder (combinational): inputs alu_op[1:0] (00 add, 01 sub, 10 funct), funct3, funct7b5, is_rtype; outputs alu_sel and funct_illegal.

Test Plan:
- rst_n pulsed low during MEMREAD -> state FETCH, strobes 0 during reset, instret=0, illegal=0.
- add R-type (0110011, f3=000, f7b5=0), mem_ready=1 -> FETCH/DECODE/EXECUTER(alu_sel=000)/ALUWB(reg_write=1) in 4 cycles, instret 0->1; with f7b5=1 -> alu_sel=001.
- lw (0000011, f3=010), mem_ready low 3 cycles in MEMREAD -> adr_src=1 held 4 cycles, then MEMWB result_src=01, reg_write=1; total 8 cycles.
- beq with zero=1 -> BRANCH pc_write=1, alu_sel=001; repeat with zero=0 -> pc_write=0; both retire (instret +2).
- opcode 0000000 -> ILLEGAL after DECODE, illegal=1, no strobes for 10 cycles, instret unchanged; rst_n clears.
- I-type f3=010 -> alu_sel=101; f3=001 -> ILLEGAL. BRANCH_EXT_EN build: bne with zero=0 -> pc_write=1.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - Shared types and encodings for the multi-cycle RISC-V control unit
// Contents: FSM state enum, opcode values, ALU sel constants, ALU-op and mux-select encodings.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REGA  = 2'b10;

  localparam logic [1:0] SRC_B_REGB = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_alu_decoder.sv
// rtl/riscv_alu_decoder.sv - Combinational ALU sel decoder for the multi-cycle control unit
// Ports: alu_op (00 add, 01 sub, 10 funct), funct3, funct7b5, is_rtype -> alu_sel, funct_illegal.
// funct_illegal reflects funct3 alone so the FSM can reject R/I-type encodings while still in DECODE.
module riscv_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_sel,
  output logic       funct_illegal
);

  logic [2:0] funct_sel;

  always_comb begin
    funct_sel     = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct3)
      3'b000:  funct_sel = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_sel = ALU_SLT;
      3'b110:  funct_sel = ALU_OR;
      3'b111:  funct_sel = ALU_AND;
      default: funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_OP_ADD: alu_sel = ALU_ADD;
      ALU_OP_SUB: alu_sel = ALU_SUB;
      default:    alu_sel = funct_sel;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// rtl/riscv_mc_control.sv - Moore FSM sequencing the multi-cycle RISC-V datapath
// Ports: clk, rst_n (async, active-low); opcode/funct3/funct7b5 from IR; zero/negative/overflow ALU flags;
//        mem_ready handshake; datapath strobes and mux selects; sticky illegal flag; instret counter.
// Macro BRANCH_EXT_EN: when defined, BRANCH also handles bne (funct3=001) and blt (funct3=100).
module riscv_mc_control
  import riscv_mc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 negative,
  input  logic                 overflow,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_sel,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t     state, next_state;
  logic [1:0] alu_op;
  logic       funct_illegal;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;
  logic       retire;
  logic       branch_ok, branch_take;

  riscv_alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .is_rtype      (opcode == OP_RTYPE),
    .alu_sel       (alu_sel),
    .funct_illegal (funct_illegal)
  );

  // Which branch flavours exist, and whether the selected one is taken.
  always_comb begin
    branch_ok   = (funct3 == F3_BEQ);
    branch_take = zero;
`ifdef BRANCH_EXT_EN
    case (funct3)
      F3_BNE: begin
        branch_ok   = 1'b1;
        branch_take = ~zero;
      end
      F3_BLT: begin
        branch_ok   = 1'b1;
        branch_take = negative ^ overflow;
      end
      default: ;
    endcase
`else
    begin : flags_unused_blk
      logic unused_flags;
      unused_flags = negative ^ overflow;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= next_state;
      if (retire) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    next_state  = state;
    pc_write_c  = 1'b0;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REGB;
    imm_src     = IMM_I;
    alu_op      = ALU_OP_ADD;
    illegal     = 1'b0;
    retire      = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = (funct3 == F3_WORD) ? S_MEMADR : S_ILLEGAL;
          OP_RTYPE:          next_state = funct_illegal ? S_ILLEGAL : S_EXECUTER;
          OP_ITYPE:          next_state = funct_illegal ? S_ILLEGAL : S_EXECUTEI;
          OP_BRANCH:         next_state = branch_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRC_A_REGA;
        alu_src_b  = SRC_B_IMM;
        imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        retire      = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRC_A_REGA;
        alu_op     = ALU_OP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRC_A_REGA;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_OP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_REGA;
        alu_op     = ALU_OP_SUB;
        pc_write_c = branch_take;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        // OldPC+4 is the link value; it lands in ALUOut and is written back in ALUWB.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_write_c = 1'b1;
        next_state = S_ALUWB;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   next_state = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so FETCH's mem_ready-driven loads cannot fire during reset.
  assign pc_write  = pc_write_c  & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign reg_write = reg_write_c & rst_n;

endmodule

// File: tb/tb_riscv_mc_control.sv
// tb/tb_riscv_mc_control.sv - Self-checking bench for riscv_mc_control against an instruction-level model
module tb_riscv_mc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5, zero, negative, overflow, mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_sel;
  logic [31:0] instret;

  riscv_mc_control #(.INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .negative(negative), .overflow(overflow), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_sel(alu_sel), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                     alu_src_a, alu_src_b, imm_src, alu_sel, illegal};

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ov(input int pc, input int adr, input int mw, input int ir,
                                      input int rw, input int rs, input int a, input int b,
                                      input int imm, input int sel, input int ill);
    return {pc[0], adr[0], mw[0], ir[0], rw[0], rs[1:0], a[1:0], b[1:0], imm[1:0], sel[2:0], ill[0]};
  endfunction

  function automatic int exp_alu(input logic [2:0] f3, input bit rtype, input logic f7);
    case (f3)
      3'b000:  return (rtype && f7) ? 1 : 0;
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  // Expected per-cycle outputs and the mem_ready value to drive in that cycle.
  string      qn[$];
  logic [16:0] qe[$];
  logic       qm[$];

  task automatic push(input string n, input logic [16:0] e, input logic m);
    qn.push_back(n); qe.push_back(e); qm.push_back(m);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic ng, input logic vf,
                       input int fw, input int mw, output bit legal);
    bit take;
    legal = 0;
    if (op == 7'b0000011 || op == 7'b0100011) legal = (f3 == 3'b010);
    else if (op == 7'b0110011 || op == 7'b0010011) legal = (f3 inside {3'b000, 3'b010, 3'b110, 3'b111});
    else if (op == 7'b1100011) begin
`ifdef BRANCH_EXT_EN
      legal = (f3 inside {3'b000, 3'b001, 3'b100});
`else
      legal = (f3 == 3'b000);
`endif
    end
    else if (op == 7'b1101111) legal = 1;

    for (int i = 0; i < fw; i++) push("FETCH_WAIT", ov(0,0,0,0,0,2,0,2,0,0,0), 1'b0);
    push("FETCH", ov(1,0,0,1,0,2,0,2,0,0,0), 1'b1);
    push("DECODE", ov(0,0,0,0,0,0,1,1,2,0,0), rbit());
    if (!legal) begin
      for (int i = 0; i < 10; i++) push("ILLEGAL", ov(0,0,0,0,0,0,0,0,0,0,1), rbit());
    end else if (op == 7'b0000011) begin
      push("MEMADR_LW", ov(0,0,0,0,0,0,2,1,0,0,0), rbit());
      for (int i = 0; i < mw; i++) push("MEMREAD_WAIT", ov(0,1,0,0,0,0,0,0,0,0,0), 1'b0);
      push("MEMREAD", ov(0,1,0,0,0,0,0,0,0,0,0), 1'b1);
      push("MEMWB", ov(0,0,0,0,1,1,0,0,0,0,0), rbit());
    end else if (op == 7'b0100011) begin
      push("MEMADR_SW", ov(0,0,0,0,0,0,2,1,1,0,0), rbit());
      for (int i = 0; i < mw; i++) push("MEMWRITE_WAIT", ov(0,1,1,0,0,0,0,0,0,0,0), 1'b0);
      push("MEMWRITE", ov(0,1,1,0,0,0,0,0,0,0,0), 1'b1);
    end else if (op == 7'b0110011) begin
      push("EXECUTER", ov(0,0,0,0,0,0,2,0,0,exp_alu(f3,1,f7),0), rbit());
      push("ALUWB", ov(0,0,0,0,1,0,0,0,0,0,0), rbit());
    end else if (op == 7'b0010011) begin
      push("EXECUTEI", ov(0,0,0,0,0,0,2,1,0,exp_alu(f3,0,f7),0), rbit());
      push("ALUWB", ov(0,0,0,0,1,0,0,0,0,0,0), rbit());
    end else if (op == 7'b1100011) begin
      take = (f3 == 3'b001) ? !z : (f3 == 3'b100) ? (ng ^ vf) : z;
      push("BRANCH", ov(take,0,0,0,0,0,2,0,0,1,0), rbit());
    end else begin
      push("JAL", ov(1,0,0,0,0,0,1,2,0,0,0), rbit());
      push("ALUWB", ov(0,0,0,0,1,0,0,0,0,0,0), rbit());
    end
  endtask

  // Entry and exit alignment: one time unit after a rising edge.
  task automatic run(input int n);
    int k = 0;
    logic [16:0] e;
    string nm;
    while (qe.size() > 0 && k < n) begin
      mem_ready = qm.pop_front();
      e = qe.pop_front();
      nm = qn.pop_front();
      @(negedge clk);
      check(nm, 32'(obs), 32'(e));
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("reset_outputs", 32'(obs), 32'(ov(0,0,0,0,0,2,0,2,0,0,0)));
    check("reset_instret", instret, 32'd0);
    @(negedge clk);
    check("reset_hold_outputs", 32'(obs), 32'(ov(0,0,0,0,0,2,0,2,0,0,0)));
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input logic ng, input logic vf,
                          input int fw, input int mw);
    bit legal;
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z; negative = ng; overflow = vf;
    build(op, f3, f7, z, ng, vf, fw, mw, legal);
    run(100000);
    if (legal) model_cnt++;
    check("instret", instret, 32'(model_cnt));
    if (!legal) do_reset();
  endtask

  logic [6:0] bad_ops[4] = '{7'h00, 7'h37, 7'h17, 7'h67};

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct3 = '0;
    funct7b5 = 1'b0; zero = 1'b0; negative = 1'b0; overflow = 1'b0;
    #3;
    check("por_outputs", 32'(obs), 32'(ov(0,0,0,0,0,2,0,2,0,0,0)));
    check("por_instret", instret, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
    do_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    do_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Reset asserted while a load is stalled in MEMREAD.
    opcode = 7'b0000011; funct3 = 3'b010;
    begin
      bit legal;
      build(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, legal);
      run(4);
      qn.delete(); qe.delete(); qm.delete();
      do_reset();
    end

    do_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(7'b0010011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    do_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2);

    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int kind;
      kind = $urandom_range(0, 11);
      f3 = 3'($urandom_range(0, 7));
      case (kind)
        0, 1:  op = 7'b0110011;
        2, 3:  op = 7'b0010011;
        4:     begin op = 7'b0000011; if ($urandom_range(0, 3) != 0) f3 = 3'b010; end
        5:     begin op = 7'b0100011; if ($urandom_range(0, 3) != 0) f3 = 3'b010; end
        6, 7:  begin op = 7'b1100011; if ($urandom_range(0, 2) == 0) f3 = 3'b000; end
        8, 9:  op = 7'b1101111;
        10:    op = bad_ops[$urandom_range(0, 3)];
        default: op = 7'b0010011;
      endcase
      do_instr(op, f3, rbit(), rbit(), rbit(), rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
